alu_mc: RTL and testbench
=========================

# alu_mc

Multicycle, parametrised successor to the combinational PLC ALU. It executes the same instruction-list operation set on WIDTH-bit operands behind a valid/ready handshake. DIV and MOD use an iterative restoring divider that takes WIDTH cycles; every other operation completes in one cycle. Carry and borrow are held in internal flag registers, and divide-by-zero is reported explicitly. Operand source selection stays upstream; the block sits between the operand muxes and the result/flag writeback.

## Interface
- WIDTH, 8, operand/result width (≥2)
- SIGNED_CMP, 0, 1 = GT/GE/LE/LT compare two's-complement; 0 = unsigned
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block accepts a request this cycle
- op_code  in  5  operation select, encoding below
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- flag_clr  in  1  synchronous clear of carry and borrow flags
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- alu_out  out  WIDTH  registered result
- alu_c_out  out  1  carry flag register
- alu_b_out  out  1  borrow flag register
- alu_flag_valid  out  1  result came from ADD or SUB
- div_err  out  1  result came from DIV/MOD with in_b==0

## Operation
- Opcode encoding: 0 AND, 1 ANDN=~(a&b), 2 OR, 3 ORN=~(a|b), 4 XOR, 5 XORN, 6 NOT=~a, 7 ADD, 8 SUB, 9 MUL (low WIDTH bits), 10 DIV, 11 MOD.
- Compares: 12 GT, 13 GE, 14 EQ, 15 NE, 16 LE, 17 LT. All compares return all-ones if true, all-zeros if false. This includes EQ and NE.
- Set/reset: 18 S = all-ones, 19 R = all-zeros.
- Loads and stores: 20 LD = a, 21 LDN = ~a, 22 ST = a, 23 STN = ~a.
- Codes 24–31 return in_a with no flag change.
- ADD: {c_flag, res} = a + b + c_flag, computed at WIDTH+1 bits.
- SUB: {b_flag, res} = a − b − b_flag, computed at WIDTH+1 bits; the MSB is the borrow.
- No other operation modifies c_flag or b_flag.
- flag_clr takes effect at the edge where it is high. If it coincides with accepting an ADD/SUB, the operation uses carry/borrow-in = 0, and the flag then takes the operation's result.
- FSM states:
  - IDLE → EXEC on an accepted non-div op, or on DIV/MOD with in_b==0.
  - IDLE → DIV on an accepted DIV/MOD with in_b≠0.
  - EXEC → DONE after one cycle.
  - DIV → DONE after WIDTH iterations.
  - DONE → IDLE on out_ready, or DONE → EXEC/DIV when a new request is accepted in the same cycle.
- Handshake:
  - in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational on out_ready.
  - Accept = in_valid & in_ready. op_code, in_a and in_b are latched at accept.
  - out_valid=1 only in DONE. alu_out, alu_flag_valid and div_err are stable while out_valid & !out_ready.
- Divider:
  - Restoring, one quotient bit per cycle, MSB first.
  - Remainder register is WIDTH+1 bits.
  - Iteration counter is $clog2(WIDTH+1) bits.
  - DIV returns the quotient; MOD returns the remainder. Both are unsigned.
- Divide by zero: no iteration. DIV gives all-ones and MOD gives in_a, with div_err=1.
- SIGNED_CMP affects only the compare ops; arithmetic is unsigned.

## Timing
- Reset state:
  - state=IDLE.
  - alu_out=0, alu_c_out=0, alu_b_out=0, alu_flag_valid=0, div_err=0, out_valid=0.
  - in_ready=1 while rst is low and the state is IDLE.
- Single-cycle ops: accept at edge N, out_valid=1 after edge N+1.
- DIV/MOD (in_b≠0): accept at edge N, out_valid=1 after edge N+WIDTH+1.
- DIV/MOD with in_b==0: latency is 1 cycle.
- Flags update at the edge entering DONE. alu_c_out and alu_b_out are visible together with out_valid.
- Back-to-back: with out_ready held high and in_valid high, one single-cycle op completes every 2 cycles (EXEC, DONE). There is no IDLE bubble.
- Reset asserted in any state aborts the operation: any result is discarded and everything returns to the reset values immediately.
- in_valid while busy (EXEC/DIV, or DONE with out_ready low) is ignored; the requester must hold it.

## Test plan
- WIDTH=8, flags clear:
  - ADD 200+100 → alu_out=0x2C, alu_c_out=1, alu_flag_valid=1.
  - Next ADD 1+1 → 0x03 (carry used), alu_c_out=0.
- SUB 3−5 with b_flag=0 → alu_out=0xFE, alu_b_out=1. flag_clr pulse → alu_b_out=0 next cycle.
- DIV 200/7 → 28 (0x1C), out_valid exactly 9 cycles after accept. MOD 200%7 → 4.
- DIV 5/0 → alu_out=0xFF, div_err=1, 1-cycle latency. MOD 5/0 → alu_out=5, div_err=1.
- Backpressure:
  - LD 0x5A with out_ready low for 3 cycles → out_valid held, alu_out=0x5A stable, in_ready=0.
  - out_ready high with a new in_valid → the new request is accepted in the same cycle.
- Reset and compares:
  - Assert rst 4 cycles into DIV 255/3 → out_valid=0 and in_ready=1 immediately; the next op's result is unaffected.
  - SIGNED_CMP=1: GT 0x80 vs 0x01 → 0x00. SIGNED_CMP=0: same inputs → 0xFF.

Source files
------------

// File: rtl/alu_mc.sv
// Multicycle PLC ALU: logic/arithmetic/compare ops in one cycle, DIV/MOD through a
// restoring divider of WIDTH iterations, behind a valid/ready handshake.
module alu_mc #(
  parameter int WIDTH      = 8,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op_code,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flag_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_c_out,
  output logic             alu_b_out,
  output logic             alu_flag_valid,
  output logic             div_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_AND  = 5'd0,  OP_ANDN = 5'd1,  OP_OR  = 5'd2,  OP_ORN = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4,  OP_XORN = 5'd5,  OP_NOT = 5'd6,  OP_ADD = 5'd7;
  localparam logic [4:0] OP_SUB  = 5'd8,  OP_MUL  = 5'd9,  OP_DIV = 5'd10, OP_MOD = 5'd11;
  localparam logic [4:0] OP_GT   = 5'd12, OP_GE   = 5'd13, OP_EQ  = 5'd14, OP_NE  = 5'd15;
  localparam logic [4:0] OP_LE   = 5'd16, OP_LT   = 5'd17, OP_S   = 5'd18, OP_R   = 5'd19;
  localparam logic [4:0] OP_LD   = 5'd20, OP_LDN  = 5'd21, OP_ST  = 5'd22, OP_STN = 5'd23;

  typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

  state_t             state_q;
  logic [4:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH:0]     rem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               c_q, bf_q;
  logic [WIDTH-1:0]   res_q;
  logic               fv_q, de_q;

  logic               accept, in_is_div;
  logic               cin, bin, gt, eq;
  logic [WIDTH:0]     add_w, sub_w;
  logic [WIDTH+1:0]   div_shift, div_sub;
  logic               div_ge;
  logic [WIDTH:0]     rem_d;
  logic [WIDTH-1:0]   exec_res_d;
  logic               exec_fv_d, exec_de_d;

  function automatic logic cmp_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED_CMP) return $signed(a) > $signed(b);
    else            return a > b;
  endfunction

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign in_is_div = (op_code == OP_DIV) | (op_code == OP_MOD);
  assign out_valid = (state_q == DONE);

  assign alu_out        = res_q;
  assign alu_c_out      = c_q;
  assign alu_b_out      = bf_q;
  assign alu_flag_valid = fv_q;
  assign div_err        = de_q;

  // A flag clear in the same cycle forces a zero carry/borrow-in.
  assign cin   = c_q & ~flag_clr;
  assign bin   = bf_q & ~flag_clr;
  assign add_w = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
  assign sub_w = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, bin};
  assign gt    = cmp_gt(a_q, b_q);
  assign eq    = (a_q == b_q);

  // Divider step: bring in the next dividend bit, subtract the divisor if it fits.
  assign div_shift = {rem_q, a_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {2'b00, b_q});
  assign div_sub   = div_shift - {2'b00, b_q};
  assign rem_d     = div_ge ? div_sub[WIDTH:0] : div_shift[WIDTH:0];

  always_comb begin
    exec_res_d = a_q;
    exec_fv_d  = 1'b0;
    exec_de_d  = 1'b0;
    case (op_q)
      OP_AND:  exec_res_d = a_q & b_q;
      OP_ANDN: exec_res_d = ~(a_q & b_q);
      OP_OR:   exec_res_d = a_q | b_q;
      OP_ORN:  exec_res_d = ~(a_q | b_q);
      OP_XOR:  exec_res_d = a_q ^ b_q;
      OP_XORN: exec_res_d = ~(a_q ^ b_q);
      OP_NOT:  exec_res_d = ~a_q;
      OP_ADD:  begin exec_res_d = add_w[WIDTH-1:0]; exec_fv_d = 1'b1; end
      OP_SUB:  begin exec_res_d = sub_w[WIDTH-1:0]; exec_fv_d = 1'b1; end
      OP_MUL:  exec_res_d = a_q * b_q;
      OP_DIV:  begin exec_res_d = {WIDTH{1'b1}}; exec_de_d = 1'b1; end
      OP_MOD:  begin exec_res_d = a_q; exec_de_d = 1'b1; end
      OP_GT:   exec_res_d = {WIDTH{gt}};
      OP_GE:   exec_res_d = {WIDTH{gt | eq}};
      OP_EQ:   exec_res_d = {WIDTH{eq}};
      OP_NE:   exec_res_d = {WIDTH{~eq}};
      OP_LE:   exec_res_d = {WIDTH{~gt}};
      OP_LT:   exec_res_d = {WIDTH{~(gt | eq)}};
      OP_S:    exec_res_d = {WIDTH{1'b1}};
      OP_R:    exec_res_d = {WIDTH{1'b0}};
      OP_LD:   exec_res_d = a_q;
      OP_LDN:  exec_res_d = ~a_q;
      OP_ST:   exec_res_d = a_q;
      OP_STN:  exec_res_d = ~a_q;
      default: exec_res_d = a_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      bf_q    <= 1'b0;
      res_q   <= '0;
      fv_q    <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      if (flag_clr) begin
        c_q  <= 1'b0;
        bf_q <= 1'b0;
      end
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            op_q    <= op_code;
            a_q     <= in_a;
            b_q     <= in_b;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= (in_is_div && (in_b != '0)) ? DIV : EXEC;
          end else if (state_q == DONE && out_ready) begin
            state_q <= IDLE;
          end
        end
        EXEC: begin
          res_q   <= exec_res_d;
          fv_q    <= exec_fv_d;
          de_q    <= exec_de_d;
          if (op_q == OP_ADD) c_q  <= add_w[WIDTH];
          if (op_q == OP_SUB) bf_q <= sub_w[WIDTH];
          state_q <= DONE;
        end
        DIV: begin
          if (cnt_q == CNT_W'(WIDTH)) begin
            res_q   <= (op_q == OP_DIV) ? a_q : rem_q[WIDTH-1:0];
            fv_q    <= 1'b0;
            de_q    <= 1'b0;
            state_q <= DONE;
          end else begin
            rem_q <= rem_d;
            a_q   <= {a_q[WIDTH-2:0], div_ge};
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: an unsigned-compare and a signed-compare instance share
// every input; expected responses are queued at accept and checked when results appear.
module tb_alu_mc;

  localparam logic [4:0] AND_ = 5'd0, ANDN = 5'd1, ADD = 5'd7, SUB = 5'd8, MUL = 5'd9;
  localparam logic [4:0] DIV_ = 5'd10, MOD = 5'd11, GT = 5'd12, EQ = 5'd14, NE = 5'd15;
  localparam logic [4:0] LT = 5'd17, LD = 5'd20;

  logic       clk = 1'b0;
  logic       rst, in_valid, flag_clr, out_ready;
  logic [4:0] op_code;
  logic [7:0] in_a, in_b;

  logic       in_ready, out_valid, alu_c_out, alu_b_out, alu_flag_valid, div_err;
  logic [7:0] alu_out;
  logic       in_ready_s, out_valid_s, alu_c_out_s, alu_b_out_s, alu_flag_valid_s, div_err_s;
  logic [7:0] alu_out_s;

  alu_mc #(.WIDTH(8), .SIGNED_CMP(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_code(op_code),
    .in_a(in_a), .in_b(in_b), .flag_clr(flag_clr), .out_valid(out_valid),
    .out_ready(out_ready), .alu_out(alu_out), .alu_c_out(alu_c_out),
    .alu_b_out(alu_b_out), .alu_flag_valid(alu_flag_valid), .div_err(div_err));

  alu_mc #(.WIDTH(8), .SIGNED_CMP(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .op_code(op_code),
    .in_a(in_a), .in_b(in_b), .flag_clr(flag_clr), .out_valid(out_valid_s),
    .out_ready(out_ready), .alu_out(alu_out_s), .alu_c_out(alu_c_out_s),
    .alu_b_out(alu_b_out_s), .alu_flag_valid(alu_flag_valid_s), .div_err(div_err_s));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [7:0] res, res_s;
    logic       c, b, fv, de;
    int         acc, lat;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   head_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor samples 1 ns before each rising edge, when the handshake is settled.
  always @(negedge clk) begin
    #4;
    if (!rst && out_valid) begin
      chk("valid_align", out_valid_s, 1);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", alu_out);
      end else begin
        if (!head_seen) begin
          head_seen = 1'b1;
          if (q[0].lat > 0) chk({q[0].name, "_latency"}, cyc - q[0].acc, q[0].lat);
        end
        if (out_ready) begin
          chk({q[0].name, "_res"},   alu_out,          q[0].res);
          chk({q[0].name, "_res_s"}, alu_out_s,        q[0].res_s);
          chk({q[0].name, "_c"},     alu_c_out,        q[0].c);
          chk({q[0].name, "_b"},     alu_b_out,        q[0].b);
          chk({q[0].name, "_fv"},    alu_flag_valid,   q[0].fv);
          chk({q[0].name, "_de"},    div_err,          q[0].de);
          chk({q[0].name, "_s_flags"}, {alu_c_out_s, alu_b_out_s, alu_flag_valid_s, div_err_s},
              {q[0].c, q[0].b, q[0].fv, q[0].de});
          void'(q.pop_front());
          head_seen = 1'b0;
        end else begin
          chk({q[0].name, "_hold_res"},   alu_out,  q[0].res);
          chk({q[0].name, "_hold_ready"}, {in_ready, in_ready_s}, 0);
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [4:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] er, input logic [7:0] ers,
                       input logic ec, input logic eb, input logic efv, input logic ede,
                       input int lat, input bit push, input bit clr, input bit orq,
                       output int tries);
    exp_t e;
    bit   r;
    @(negedge clk);
    op_code = op; in_a = a; in_b = b; in_valid = 1'b1; flag_clr = clr; out_ready = orq;
    tries = 0;
    r = 1'b0;
    while (!r && tries < 100) begin
      #4;
      r = in_ready;
      if (r && push) begin
        e.name = nm; e.res = er; e.res_s = ers; e.c = ec; e.b = eb; e.fv = efv; e.de = ede;
        e.acc = cyc + 1; e.lat = lat;
        q.push_back(e);
      end
      @(posedge clk);
      tries++;
      if (!r) @(negedge clk);
    end
    #1;
    in_valid = 1'b0;
    flag_clr = 1'b0;
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got timeout expected accept", nm);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
      q.delete();
      head_seen = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; flag_clr = 1'b0; out_ready = 1'b1;
    op_code = '0; in_a = '0; in_b = '0;
    #2;
    chk("reset_outputs", {out_valid, alu_out, alu_c_out, alu_b_out, alu_flag_valid, div_err}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);

    issue("add1", ADD, 8'd200, 8'd100, 8'h2C, 8'h2C, 1, 0, 1, 0, 1, 1, 0, 1, t);
    issue("add2", ADD, 8'd1,   8'd1,   8'h03, 8'h03, 0, 0, 1, 0, 1, 1, 0, 1, t);
    issue("sub1", SUB, 8'd3,   8'd5,   8'hFE, 8'hFE, 0, 1, 1, 0, 1, 1, 0, 1, t);
    drain();
    chk("borrow_before_clr", alu_b_out, 1);
    @(negedge clk);
    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    chk("borrow_after_clr", {alu_b_out, alu_b_out_s}, 0);

    issue("div200_7", DIV_, 8'd200, 8'd7, 8'h1C, 8'h1C, 0, 0, 0, 0, 9, 1, 0, 1, t);
    issue("mod200_7", MOD,  8'd200, 8'd7, 8'h04, 8'h04, 0, 0, 0, 0, 9, 1, 0, 1, t);
    issue("div5_0",   DIV_, 8'd5,   8'd0, 8'hFF, 8'hFF, 0, 0, 0, 1, 1, 1, 0, 1, t);
    issue("mod5_0",   MOD,  8'd5,   8'd0, 8'h05, 8'h05, 0, 0, 0, 1, 1, 1, 0, 1, t);
    issue("gt80_01",  GT,   8'h80,  8'h01, 8'hFF, 8'h00, 0, 0, 0, 0, 1, 1, 0, 1, t);
    issue("lt80_01",  LT,   8'h80,  8'h01, 8'h00, 8'hFF, 0, 0, 0, 0, 1, 1, 0, 1, t);
    issue("eq5_5",    EQ,   8'd5,   8'd5,  8'hFF, 8'hFF, 0, 0, 0, 0, 1, 1, 0, 1, t);
    issue("ne5_5",    NE,   8'd5,   8'd5,  8'h00, 8'h00, 0, 0, 0, 0, 1, 1, 0, 1, t);
    issue("and",      AND_, 8'hF0,  8'h3C, 8'h30, 8'h30, 0, 0, 0, 0, 1, 1, 0, 1, t);
    drain();

    issue("ld5a", LD, 8'h5A, 8'h00, 8'h5A, 8'h5A, 0, 0, 0, 0, 1, 1, 0, 0, t);
    repeat (4) @(negedge clk);
    issue("andn", ANDN, 8'hF0, 8'h3C, 8'hCF, 8'hCF, 0, 0, 0, 0, 1, 1, 0, 1, t);
    chk("same_cycle_accept_tries", t, 1);
    issue("mul", MUL, 8'd20, 8'd13, 8'h04, 8'h04, 0, 0, 0, 0, 1, 1, 0, 1, t);
    chk("back_to_back_tries", t, 2);
    drain();

    issue("add_ff_01", ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 1, 0, 1, 0, 1, 1, 0, 1, t);
    drain();
    issue("add_clr",   ADD, 8'd2,  8'd3,  8'h05, 8'h05, 0, 0, 1, 0, 1, 1, 1, 1, t);
    drain();

    issue("div_abort", DIV_, 8'd255, 8'd3, 8'h55, 8'h55, 0, 0, 0, 0, 9, 0, 0, 1, t);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", {out_valid, out_valid_s}, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_regs", {alu_out, alu_c_out, alu_b_out, alu_flag_valid, div_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    issue("add_after_rst", ADD, 8'd10, 8'd20, 8'h1E, 8'h1E, 0, 0, 1, 0, 1, 1, 0, 1, t);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
